// File: rtl/tage_pkg.sv
// tage_pkg: shared TAGE types and constants (state enum, u-counter width, table count).
// Widths normally come from the common defines; TAGE_IDX_WIDTH falls back to 9 here
// when no project-wide definition has been provided.
`ifndef TAGE_IDX_WIDTH
`define TAGE_IDX_WIDTH 9
`endif

package tage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } uage_state_e;

    localparam int TAGE_U_W        = 2;
    localparam int TAGE_NUM_TABLES = 4;

endpackage

// File: rtl/tage_period_ctr.sv
// tage_period_ctr: retirement counter with synchronous clear, count enable and terminal count.
//   clk_i, rst_i : clock, synchronous active-high reset
//   clr_i        : force the count to 0 (wins over en_i)
//   en_i         : increment this cycle
//   tc_o         : count is all ones
module tage_period_ctr #(
    parameter int W = 18
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = clr_i ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign tc_o = &cnt_q;

endmodule

// File: rtl/tage_u_aging_ctrl.sv
// tage_u_aging_ctrl: periodic u-counter aging sweep over all tagged TAGE tables.
//   br_retire_i  : a branch resolved; counted while idle, expiry starts a sweep
//   force_i      : start a sweep now (ignored while sweeping)
//   upd_busy_i   : predictor owns the table write port; clear request withdrawn
//   clr_*_o/clr_ready_i : valid/ready clear request (index, table mask, u bit)
//   busy_o       : sweep in progress; sweep_done_o : one-cycle pulse after the last index
// Optional TAGE_UAGING_STATS_EN adds sweep_cnt_o (wrapping) and stall_cnt_o (saturating).
`ifndef TAGE_IDX_WIDTH
`define TAGE_IDX_WIDTH 9
`endif

module tage_u_aging_ctrl
    import tage_pkg::*;
#(
    parameter int IDX_W       = `TAGE_IDX_WIDTH,
    parameter int NUM_TABLES  = TAGE_NUM_TABLES,
    parameter int PERIOD_LOG2 = 18
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  br_retire_i,
    input  logic                  upd_busy_i,
    input  logic                  force_i,
    output logic                  clr_valid_o,
    input  logic                  clr_ready_i,
    output logic [IDX_W-1:0]      clr_idx_o,
    output logic [NUM_TABLES-1:0] clr_tbl_mask_o,
    output logic                  clr_bit_o,
    output logic                  busy_o,
    output logic                  sweep_done_o
`ifdef TAGE_UAGING_STATS_EN
    ,
    output logic [7:0]            sweep_cnt_o,
    output logic [15:0]           stall_cnt_o
`endif
);

    uage_state_e      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             bit_q, bit_d;
    logic             idle, sweeping, tc, trigger, xfer;

    assign idle     = state_q == ST_IDLE;
    assign sweeping = state_q == ST_SWEEP;
    // a forced start and a period expiry in the same cycle collapse into one sweep
    assign trigger  = idle && (force_i || (tc && br_retire_i));

    // counter is held at zero outside IDLE and restarts on every trigger
    tage_period_ctr #(.W(PERIOD_LOG2)) u_period (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (trigger || !idle),
        .en_i  (idle && br_retire_i),
        .tc_o  (tc)
    );

    // update traffic has priority over aging, so valid drops combinationally
    assign clr_valid_o    = sweeping && !upd_busy_i;
    assign xfer           = clr_valid_o && clr_ready_i;
    assign clr_idx_o      = idx_q;
    assign clr_tbl_mask_o = {NUM_TABLES{clr_valid_o}};
    assign clr_bit_o      = bit_q;
    assign busy_o         = sweeping;
    assign sweep_done_o   = state_q == ST_DONE;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = trigger ? ST_SWEEP : ST_IDLE;
            ST_SWEEP: state_d = (xfer && &idx_q) ? ST_DONE : ST_SWEEP;
            default:  state_d = ST_IDLE;
        endcase
    end

    // index wraps naturally to 0 on the last transfer
    always_comb idx_d = xfer ? idx_q + 1'b1 : idx_q;
    always_comb bit_d = sweep_done_o ? ~bit_q : bit_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            bit_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            bit_q   <= bit_d;
        end
    end

`ifdef TAGE_UAGING_STATS_EN
    logic [7:0]  sweep_cnt_q;
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sweep_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            sweep_cnt_q <= sweep_done_o ? sweep_cnt_q + 1'b1 : sweep_cnt_q;
            stall_cnt_q <= (sweeping && !xfer && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
        end
    end

    assign sweep_cnt_o = sweep_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_tage_u_aging_ctrl.sv
// tb_tage_u_aging_ctrl: scoreboard bench for the u-counter aging scheduler (PERIOD_LOG2=3, IDX_W=2).
module tb_tage_u_aging_ctrl;

    localparam int IDX_W = 2;
    localparam int NT    = 4;
    localparam int PL    = 3;

    logic            clk = 1'b0;
    logic            rst_i = 1'b1;
    logic            br_retire_i = 1'b0;
    logic            upd_busy_i = 1'b0;
    logic            force_i = 1'b0;
    logic            clr_ready_i = 1'b1;
    logic            clr_valid_o;
    logic [IDX_W-1:0] clr_idx_o;
    logic [NT-1:0]   clr_tbl_mask_o;
    logic            clr_bit_o;
    logic            busy_o;
    logic            sweep_done_o;
`ifdef TAGE_UAGING_STATS_EN
    logic [7:0]      sweep_cnt_o;
    logic [15:0]     stall_cnt_o;
`endif

    always #5 clk = ~clk;

    tage_u_aging_ctrl #(.IDX_W(IDX_W), .NUM_TABLES(NT), .PERIOD_LOG2(PL)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .br_retire_i    (br_retire_i),
        .upd_busy_i     (upd_busy_i),
        .force_i        (force_i),
        .clr_valid_o    (clr_valid_o),
        .clr_ready_i    (clr_ready_i),
        .clr_idx_o      (clr_idx_o),
        .clr_tbl_mask_o (clr_tbl_mask_o),
        .clr_bit_o      (clr_bit_o),
        .busy_o         (busy_o),
        .sweep_done_o   (sweep_done_o)
`ifdef TAGE_UAGING_STATS_EN
        ,
        .sweep_cnt_o    (sweep_cnt_o),
        .stall_cnt_o    (stall_cnt_o)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [IDX_W:0] exp_q[$];
    logic           exp_bit = 1'b1;
    int             len = 0;
    int             last_len = 0;
    int             done_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic push_sweep(input logic b);
        for (int i = 0; i < (1 << IDX_W); i++) exp_q.push_back({b, IDX_W'(i)});
    endtask

    task automatic wait_done;
        int n = 0;
        while (!sweep_done_o && n < 20) begin
            tick();
            n++;
        end
        check("done_timeout", 32'(n < 20), 1);
        #1;
        check("done_busy", busy_o, 0);
        check("done_valid", clr_valid_o, 0);
    endtask

    task automatic finish_sweep(input int exp_len);
        wait_done();
        tick();
        #1;
        check("done_pulse", sweep_done_o, 0);
        check("sweep_len", last_len, exp_len);
        check("queue_drained", exp_q.size(), 0);
        exp_bit = ~exp_bit;
        check("bit_toggle", clr_bit_o, exp_bit);
    endtask

    // monitor: pops the scoreboard on every accepted clear, measures sweep length
    always @(negedge clk) begin
        if (rst_i) begin
            len = 0;
        end else begin
            if (!clr_valid_o) check("mask_idle", clr_tbl_mask_o, 0);
            if (clr_valid_o && clr_ready_i) begin
                if (exp_q.size() == 0) check("xfer_unexpected", 1, 0);
                else check("xfer", {clr_tbl_mask_o, clr_bit_o, clr_idx_o}, {4'hF, exp_q.pop_front()});
            end
            if (busy_o) len++;
            if (sweep_done_o) begin
                last_len = len;
                len = 0;
                done_cnt++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        rst_i = 1'b0;
        #1;
        check("rst_valid", clr_valid_o, 0);
        check("rst_idx", clr_idx_o, 0);
        check("rst_mask", clr_tbl_mask_o, 0);
        check("rst_bit", clr_bit_o, 1);
        check("rst_busy", busy_o, 0);
        check("rst_done", sweep_done_o, 0);

        // period expiry, unstalled sweep clearing MSB
        push_sweep(exp_bit);
        br_retire_i = 1'b1;
        repeat (7) begin
            tick();
            #1;
            check("busy_pre7", busy_o, 0);
        end
        tick();
        br_retire_i = 1'b0;
        #1;
        check("s1_valid", clr_valid_o, 1);
        check("s1_idx", clr_idx_o, 0);
        check("s1_mask", clr_tbl_mask_o, 4'hF);
        check("s1_bit", clr_bit_o, 1);
        check("s1_busy", busy_o, 1);
        finish_sweep(4);

        // second sweep clears LSB, two update-busy stall cycles at idx 1
        push_sweep(exp_bit);
        br_retire_i = 1'b1;
        repeat (8) tick();
        br_retire_i = 1'b0;
        #1;
        check("s2_bit", clr_bit_o, 0);
        check("s2_valid0", clr_valid_o, 1);
        tick();
        upd_busy_i = 1'b1;
        #1;
        check("s2_stall_valid_a", clr_valid_o, 0);
        check("s2_stall_idx_a", clr_idx_o, 1);
        tick();
        #1;
        check("s2_stall_valid_b", clr_valid_o, 0);
        check("s2_stall_idx_b", clr_idx_o, 1);
        tick();
        upd_busy_i = 1'b0;
        #1;
        check("s2_resume_valid", clr_valid_o, 1);
        check("s2_resume_idx", clr_idx_o, 1);
        finish_sweep(6);

        // force with counter at 5; force during sweep ignored; one ready stall
        br_retire_i = 1'b1;
        repeat (5) tick();
        br_retire_i = 1'b0;
        push_sweep(exp_bit);
        force_i = 1'b1;
        tick();
        force_i = 1'b0;
        #1;
        check("f_busy", busy_o, 1);
        check("f_idx", clr_idx_o, 0);
        check("f_bit", clr_bit_o, 1);
        tick();
        force_i = 1'b1;
        clr_ready_i = 1'b0;
        #1;
        check("f_notready_idx", clr_idx_o, 1);
        tick();
        force_i = 1'b0;
        clr_ready_i = 1'b1;
        #1;
        check("f_hold_idx", clr_idx_o, 1);
        finish_sweep(5);
        repeat (3) begin
            tick();
            #1;
            check("f_no_resweep", busy_o, 0);
        end
`ifdef TAGE_UAGING_STATS_EN
        check("stat_sweeps", sweep_cnt_o, 3);
        check("stat_stalls", stall_cnt_o, 3);
`endif

        // counter was cleared by force: 7 retirements do not start a sweep
        br_retire_i = 1'b1;
        repeat (7) begin
            tick();
            #1;
            check("ctr_cleared", busy_o, 0);
        end
        push_sweep(exp_bit);
        tick();
        br_retire_i = 1'b0;
        #1;
        check("r_busy", busy_o, 1);
        check("r_bit", clr_bit_o, 0);
        tick();
        tick();
        #1;
        check("r_idx2", clr_idx_o, 2);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        exp_q.delete();
        exp_bit = 1'b1;
        #1;
        check("r_valid", clr_valid_o, 0);
        check("r_busy_after", busy_o, 0);
        check("r_bit_after", clr_bit_o, 1);
        check("r_idx_after", clr_idx_o, 0);
        check("r_done_after", sweep_done_o, 0);
        repeat (3) tick();
        check("r_no_done", done_cnt, 3);
`ifdef TAGE_UAGING_STATS_EN
        check("r_stat_sweeps", sweep_cnt_o, 0);
        check("r_stat_stalls", stall_cnt_o, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
